wb_port_arbiter: RTL and testbench

- Shares the single register-file write port (wa3/wd3/write_enable) between two writers: the in-order pipeline Writeback stage, and a long-latency unit (mult/div) returning results out of band.
- Pipeline writes always win the port.
- Long-latency results are buffered in a small FIFO and drained into idle port cycles.
- Provides a forwarding lookup into buffered results, and kills stale buffered writes that a pipeline write supersedes.

---
 rtl/wb_port_arbiter_if.sv | 32 +++
 rtl/wb_port_arbiter.sv | 115 +++++++++++
 tb/tb_wb_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, long-latency result handshake,
// the shared write port, and the forwarding lookup into deferred results.
interface wb_port_arbiter_if #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
);
    logic                         wb_en;
    logic [IDX_W-1:0]             wb_addr;
    logic [DATA_W-1:0]            wb_data;
    logic                         lu_valid;
    logic [IDX_W-1:0]             lu_addr;
    logic [DATA_W-1:0]            lu_data;
    logic                         lu_ready;
    logic [IDX_W-1:0]             wa3;
    logic [DATA_W-1:0]            wd3;
    logic                         write_enable;
    logic [IDX_W-1:0]             q_idx;
    logic                         q_hit;
    logic [DATA_W-1:0]            q_data;
    logic [$clog2(DEPTH+1)-1:0]   pending;

    modport master (
        output wb_en, wb_addr, wb_data, lu_valid, lu_addr, lu_data, q_idx,
        input  lu_ready, wa3, wd3, write_enable, q_hit, q_data, pending
    );

    modport slave (
        input  wb_en, wb_addr, wb_data, lu_valid, lu_addr, lu_data, q_idx,
        output lu_ready, wa3, wd3, write_enable, q_hit, q_data, pending
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between pipeline writeback (always wins) and
// a deferred-result FIFO fed by a long-latency unit; dead entries are popped silently.
module wb_port_arbiter #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DEPTH-1:0]  live_q, live_d;
    logic [IDX_W-1:0]  addr_q [DEPTH];
    logic [IDX_W-1:0]  addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];

    logic              wb_win, fifo_empty, lu_ready_w, xfer, pop, bypass, push;
    logic              we_w, hit_w;
    logic [IDX_W-1:0]  wa3_w;
    logic [DATA_W-1:0] wd3_w, qd_w;

    always_comb begin
        wb_win     = !reset && bus.wb_en && (bus.wb_addr != '0);
        fifo_empty = (cnt_q == '0);
        lu_ready_w = !reset && (cnt_q < FULL_CNT);
        xfer       = bus.lu_valid && lu_ready_w;
        pop        = !reset && !wb_win && !fifo_empty;
        bypass     = !reset && !wb_win && fifo_empty && xfer && (bus.lu_addr != '0);
        push       = xfer && !bypass;

        we_w  = 1'b0;
        wa3_w = '0;
        wd3_w = '0;
        if (wb_win) begin
            we_w  = 1'b1;
            wa3_w = bus.wb_addr;
            wd3_w = bus.wb_data;
        end else if (pop) begin
            we_w  = live_q[head_q];
            wa3_w = addr_q[head_q];
            wd3_w = data_q[head_q];
        end else if (bypass) begin
            we_w  = 1'b1;
            wa3_w = bus.lu_addr;
            wd3_w = bus.lu_data;
        end
    end

    // Scan oldest to youngest so the youngest live match is the one left standing.
    always_comb begin
        hit_w = 1'b0;
        qd_w  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset && (bus.q_idx != '0) && (CNT_W'(i) < cnt_q)
                && live_q[head_q + PTR_W'(i)]
                && (addr_q[head_q + PTR_W'(i)] == bus.q_idx)) begin
                hit_w = 1'b1;
                qd_w  = data_q[head_q + PTR_W'(i)];
            end
        end
    end

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        live_d = live_q;
        addr_d = addr_q;
        data_d = data_q;
        if (wb_win) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == bus.wb_addr) live_d[i] = 1'b0;
            end
        end
        if (pop) head_d = head_q + PTR_W'(1);
        // A result landing alongside a pipeline write to the same register is already stale.
        if (push) begin
            live_d[tail_q] = (bus.lu_addr != '0) && !(wb_win && (bus.lu_addr == bus.wb_addr));
            addr_d[tail_q] = bus.lu_addr;
            data_d[tail_q] = bus.lu_data;
            tail_d         = tail_q + PTR_W'(1);
        end
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            live_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            live_q <= live_d;
        end
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign bus.lu_ready     = lu_ready_w;
    assign bus.write_enable = we_w;
    assign bus.wa3          = wa3_w;
    assign bus.wd3          = wd3_w;
    assign bus.q_hit        = hit_w;
    assign bus.q_data       = qd_w;
    assign bus.pending      = cnt_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic
// against a queue-based reference model and a shadow register file.
module tb_wb_port_arbiter;
    localparam int DEPTH  = 2;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;
    localparam int PW     = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    wb_port_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit          live;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] exp_rf [32];
    logic [31:0] obs_rf [32];
    int          n_tests = 0;
    int          n_fail  = 0;

    logic          e_we, e_rdy, e_hit, e_xfer, e_wbwin, e_bypass;
    logic [4:0]    e_wa3;
    logic [31:0]   e_wd3, e_qd;
    logic [PW-1:0] e_pend;
    logic          o_we;
    logic [4:0]    o_wa3;
    logic [31:0]   o_wd3;

    // Reference: the FIFO is a plain queue; port choice follows the priority list directly.
    task automatic predict();
        e_rdy    = !reset && (mq.size() < DEPTH);
        e_xfer   = bus.lu_valid && e_rdy;
        e_wbwin  = !reset && bus.wb_en && (bus.wb_addr != 0);
        e_bypass = 1'b0;
        e_we     = 1'b0;
        e_wa3    = '0;
        e_wd3    = '0;
        if (reset) begin
        end else if (e_wbwin) begin
            e_we = 1'b1; e_wa3 = bus.wb_addr; e_wd3 = bus.wb_data;
        end else if (mq.size() > 0) begin
            e_we = mq[0].live; e_wa3 = mq[0].addr; e_wd3 = mq[0].data;
        end else if (e_xfer && bus.lu_addr != 0) begin
            e_bypass = 1'b1;
            e_we = 1'b1; e_wa3 = bus.lu_addr; e_wd3 = bus.lu_data;
        end
        e_hit = 1'b0;
        e_qd  = '0;
        if (!reset && bus.q_idx != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (mq[i].live && mq[i].addr == bus.q_idx) begin
                    e_hit = 1'b1; e_qd = mq[i].data;
                    break;
                end
            end
        end
        e_pend = PW'(mq.size());
        o_we  = bus.write_enable;
        o_wa3 = bus.wa3;
        o_wd3 = bus.wd3;
    endtask

    task automatic setup(input logic rst, input logic wen, input logic [4:0] wa,
                         input logic [31:0] wd, input logic lv, input logic [4:0] la,
                         input logic [31:0] ld, input logic [4:0] qi);
        @(negedge clk);
        reset       = rst;
        bus.wb_en   = wen;
        bus.wb_addr = wa;
        bus.wb_data = wd;
        bus.lu_valid = lv;
        bus.lu_addr = la;
        bus.lu_data = ld;
        bus.q_idx   = qi;
        #1;
        predict();
    endtask

    task automatic tick();
        @(posedge clk);
        if (o_we) obs_rf[o_wa3] = o_wd3;
        if (e_we) exp_rf[e_wa3] = e_wd3;
        if (reset) begin
            mq.delete();
        end else begin
            if (e_wbwin)
                foreach (mq[i]) if (mq[i].addr == bus.wb_addr) mq[i].live = 1'b0;
            if (!e_wbwin && mq.size() > 0) void'(mq.pop_front());
            if (e_xfer && !e_bypass)
                mq.push_back('{live: (bus.lu_addr != 0) && !(e_wbwin && bus.lu_addr == bus.wb_addr),
                               addr: bus.lu_addr, data: bus.lu_data});
        end
    endtask

    task automatic test_reset();
        setup(1, 1, 5'd3, 32'h1234, 1, 5'd8, 32'h5678, 5'd8);
        n_tests++;
        if ({bus.write_enable, bus.wa3, bus.wd3, bus.lu_ready, bus.q_hit, bus.q_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs we=%0b wa3=%0d wd3=%h rdy=%0b hit=%0b qd=%h want all 0",
                     bus.write_enable, bus.wa3, bus.wd3, bus.lu_ready, bus.q_hit, bus.q_data);
        end
        tick();
        setup(0, 0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({bus.pending, bus.lu_ready} !== {PW'(0), 1'b1}) begin
            n_fail++;
            $display("FAIL reset_release pending=%0d rdy=%0b want 0/1", bus.pending, bus.lu_ready);
        end
        tick();
    endtask

    task automatic test_bypass();
        setup(0, 0, 0, 0, 1, 5'd8, 32'hDEAD_BEEF, 0);
        n_tests++;
        if ({bus.write_enable, bus.wa3, bus.wd3} !== {1'b1, 5'd8, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL bypass_write we=%0b wa3=%0d wd3=%h want 1/8/deadbeef",
                     bus.write_enable, bus.wa3, bus.wd3);
        end
        tick();
        setup(0, 0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (bus.pending !== PW'(0)) begin
            n_fail++;
            $display("FAIL bypass_pending got=%0d want 0", bus.pending);
        end
        tick();
    endtask

    task automatic test_defer();
        setup(0, 1, 5'd3, 32'h11, 1, 5'd9, 32'h22, 0);
        n_tests++;
        if ({bus.write_enable, bus.wa3, bus.wd3, bus.lu_ready} !== {1'b1, 5'd3, 32'h11, 1'b1}) begin
            n_fail++;
            $display("FAIL defer_c0 we=%0b wa3=%0d wd3=%h rdy=%0b want 1/3/11/1",
                     bus.write_enable, bus.wa3, bus.wd3, bus.lu_ready);
        end
        tick();
        setup(0, 0, 0, 0, 0, 0, 0, 5'd9);
        n_tests++;
        if ({bus.pending, bus.write_enable, bus.wa3, bus.wd3} !== {PW'(1), 1'b1, 5'd9, 32'h22}) begin
            n_fail++;
            $display("FAIL defer_c1 pending=%0d we=%0b wa3=%0d wd3=%h want 1/1/9/22",
                     bus.pending, bus.write_enable, bus.wa3, bus.wd3);
        end
        n_tests++;
        if ({bus.q_hit, bus.q_data} !== {1'b1, 32'h22}) begin
            n_fail++;
            $display("FAIL defer_fwd hit=%0b qd=%h want 1/22", bus.q_hit, bus.q_data);
        end
        tick();
        setup(0, 0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (bus.pending !== PW'(0)) begin
            n_fail++;
            $display("FAIL defer_drained pending=%0d want 0", bus.pending);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [2:0] want_rdy = 3'b110;
        for (int k = 0; k < 3; k++) begin
            setup(0, 1, 5'd4, 32'h40 + k, 1, 5'(5 + k), 32'h50 + k, 0);
            n_tests++;
            if ({bus.lu_ready, bus.write_enable, bus.wa3} !== {want_rdy[2 - k], 1'b1, 5'd4}) begin
                n_fail++;
                $display("FAIL bp_cycle%0d rdy=%0b we=%0b wa3=%0d want %0b/1/4",
                         k, bus.lu_ready, bus.write_enable, bus.wa3, want_rdy[2 - k]);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            setup(0, 0, 0, 0, 0, 0, 0, 0);
            n_tests++;
            if ({bus.pending, bus.write_enable, bus.wa3, bus.wd3} !==
                {PW'(2 - k), 1'b1, 5'(5 + k), 32'h50 + k}) begin
                n_fail++;
                $display("FAIL bp_drain%0d pending=%0d we=%0b wa3=%0d wd3=%h want %0d/1/%0d/%h",
                         k, bus.pending, bus.write_enable, bus.wa3, bus.wd3, 2 - k, 5 + k, 32'h50 + k);
            end
            tick();
        end
    endtask

    task automatic test_supersede();
        setup(0, 1, 5'd1, 32'h01, 1, 5'd10, 32'hAA, 0);
        tick();
        setup(0, 1, 5'd10, 32'hBB, 0, 0, 0, 5'd10);
        n_tests++;
        if ({bus.q_hit, bus.q_data, bus.wa3, bus.wd3} !== {1'b1, 32'hAA, 5'd10, 32'hBB}) begin
            n_fail++;
            $display("FAIL sup_before hit=%0b qd=%h wa3=%0d wd3=%h want 1/aa/10/bb",
                     bus.q_hit, bus.q_data, bus.wa3, bus.wd3);
        end
        tick();
        setup(0, 0, 0, 0, 0, 0, 0, 5'd10);
        n_tests++;
        if ({bus.q_hit, bus.write_enable, bus.pending} !== {1'b0, 1'b0, PW'(1)}) begin
            n_fail++;
            $display("FAIL sup_dead_pop hit=%0b we=%0b pending=%0d want 0/0/1",
                     bus.q_hit, bus.write_enable, bus.pending);
        end
        tick();
        setup(0, 0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if ({bus.pending, obs_rf[10]} !== {PW'(0), 32'hBB}) begin
            n_fail++;
            $display("FAIL sup_final pending=%0d r10=%h want 0/bb", bus.pending, obs_rf[10]);
        end
        tick();
    endtask

    task automatic test_zero_addr();
        setup(0, 1, 5'd0, 32'h55, 1, 5'd0, 32'h77, 5'd0);
        n_tests++;
        if ({bus.write_enable, bus.q_hit, bus.pending} !== {1'b0, 1'b0, PW'(0)}) begin
            n_fail++;
            $display("FAIL zero_c0 we=%0b hit=%0b pending=%0d want 0/0/0",
                     bus.write_enable, bus.q_hit, bus.pending);
        end
        tick();
        setup(0, 0, 0, 0, 0, 0, 0, 5'd0);
        n_tests++;
        if ({bus.write_enable, bus.q_hit, bus.pending} !== {1'b0, 1'b0, e_pend}) begin
            n_fail++;
            $display("FAIL zero_c1 we=%0b hit=%0b pending=%0d want 0/0/%0d",
                     bus.write_enable, bus.q_hit, bus.pending, e_pend);
        end
        tick();
        setup(0, 0, 0, 0, 0, 0, 0, 0);
        n_tests++;
        if (bus.pending !== PW'(0)) begin
            n_fail++;
            $display("FAIL zero_drained pending=%0d want 0", bus.pending);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        setup(0, 1, 5'd1, 32'h1, 1, 5'd12, 32'hC1, 0);
        tick();
        setup(0, 1, 5'd1, 32'h2, 1, 5'd13, 32'hC2, 0);
        tick();
        setup(1, 1, 5'd2, 32'h3, 1, 5'd14, 32'hC3, 5'd12);
        n_tests++;
        if ({bus.write_enable, bus.wa3, bus.wd3, bus.lu_ready, bus.q_hit, bus.q_data} !== '0) begin
            n_fail++;
            $display("FAIL rmid_during we=%0b wa3=%0d wd3=%h rdy=%0b hit=%0b qd=%h want all 0",
                     bus.write_enable, bus.wa3, bus.wd3, bus.lu_ready, bus.q_hit, bus.q_data);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            setup(0, 0, 0, 0, 0, 0, 0, 5'(12 + k));
            n_tests++;
            if ({bus.pending, bus.lu_ready, bus.q_hit, bus.write_enable} !== {PW'(0), 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rmid_after%0d pending=%0d rdy=%0b hit=%0b we=%0b want 0/1/0/0",
                         k, bus.pending, bus.lu_ready, bus.q_hit, bus.write_enable);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int bad;
        for (int c = 0; c < 400; c++) begin
            setup(($urandom_range(0, 39) == 0), ($urandom_range(0, 1) == 1),
                  5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 6),
                  5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
            n_tests++;
            if ({bus.write_enable, bus.wa3, bus.wd3, bus.lu_ready, bus.q_hit, bus.q_data, bus.pending} !==
                {e_we, e_wa3, e_wd3, e_rdy, e_hit, e_qd, e_pend}) begin
                n_fail++;
                $display("FAIL rand_c%0d got we=%0b wa3=%0d wd3=%h rdy=%0b hit=%0b qd=%h pend=%0d want %0b/%0d/%h/%0b/%0b/%h/%0d",
                         c, bus.write_enable, bus.wa3, bus.wd3, bus.lu_ready, bus.q_hit, bus.q_data,
                         bus.pending, e_we, e_wa3, e_wd3, e_rdy, e_hit, e_qd, e_pend);
            end
            tick();
        end
        bad = 0;
        for (int r = 0; r < 32; r++) if (obs_rf[r] !== exp_rf[r]) bad++;
        n_tests++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL rand_regfile mismatching_regs=%0d want 0", bad);
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            exp_rf[r] = '0;
            obs_rf[r] = '0;
        end
        bus.wb_en = 0; bus.wb_addr = 0; bus.wb_data = 0;
        bus.lu_valid = 0; bus.lu_addr = 0; bus.lu_data = 0; bus.q_idx = 0;
        repeat (2) @(posedge clk);
        test_reset();
        test_bypass();
        test_defer();
        test_backpressure();
        test_supersede();
        test_zero_addr();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
